// File: rtl/stoch_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts the 1s in a unipolar bitstream over a
// window of WINDOW valid samples and publishes the count with a one-cycle done pulse.
module stoch_bitstream_decoder #(
    parameter int WL     = 8,
    parameter int WINDOW = (1 << WL) - 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic          clear,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          busy,
    output logic          done,
    output logic [WL-1:0] result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Index of the final sample in the window; samp_q counts accepted samples from 0.
    localparam logic [WL-1:0] LAST_IDX = WL'(WINDOW - 1);

    logic [1:0]    state_q,  state_d;
    logic [WL-1:0] ones_q,   ones_d;
    logic [WL-1:0] samp_q,   samp_d;
    logic [WL-1:0] result_q, result_d;
    logic [WL-1:0] ones_inc;

    assign ones_inc = ones_q + WL'(bit_in);

    always_comb begin
        state_d  = state_q;
        ones_d   = ones_q;
        samp_d   = samp_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COUNT;
                    ones_d  = '0;
                    samp_d  = '0;
                end
            end
            S_COUNT: begin
                if (bit_valid) begin
                    ones_d = ones_inc;
                    samp_d = samp_q + WL'(1);
                    if (samp_q == LAST_IDX) begin
                        state_d  = S_DONE;
                        result_d = ones_inc;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ones_d  = '0;
                samp_d  = '0;
            end
        endcase

        // Abort wins over everything else but leaves the last published result intact.
        if (clear) begin
            state_d  = S_IDLE;
            ones_d   = '0;
            samp_d   = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            ones_q   <= '0;
            samp_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            samp_q   <= samp_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_COUNT);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_stoch_bitstream_decoder.sv
// Scoreboard bench for stoch_bitstream_decoder: a WL=4/WINDOW=15 instance and a
// WL=4/WINDOW=1 instance; expected results are queued by stimulus and popped on done.
module tb_stoch_bitstream_decoder;

    logic       clk;
    logic       rst_b;

    logic       start, clear, bit_in, bit_valid;
    logic       busy, done;
    logic [3:0] result;

    logic       start1, clear1, bit_in1, bit_valid1;
    logic       busy1, done1;
    logic [3:0] result1;

    int tests;
    int fails;
    int busy_cnt;
    int exp_q[$];
    int exp1_q[$];

    stoch_bitstream_decoder #(.WL(4), .WINDOW(15)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .clear     (clear),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    stoch_bitstream_decoder #(.WL(4), .WINDOW(1)) dut1 (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start1),
        .clear     (clear1),
        .bit_in    (bit_in1),
        .bit_valid (bit_valid1),
        .busy      (busy1),
        .done      (done1),
        .result    (result1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %0d", name, act);
        end
    endtask

    // Monitors: each done pulse consumes one queued expected result.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("result_w15", int'(result), exp_q.pop_front());
            end
        end
        if (done1) begin
            if (exp1_q.size() == 0) begin
                chk("unexpected_done_w1", 1, 0);
            end else begin
                chk("result_w1", int'(result1), exp1_q.pop_front());
            end
        end
        if (busy) busy_cnt++;
    end

    // One full conversion on the WINDOW=15 instance. gap inserts an invalid cycle
    // before every sample but the first; start is re-pulsed at sample start_at.
    task automatic conv(input string name, input logic [14:0] bits, input bit gap,
                        input int start_at, input int exp_res, input int exp_busy);
        exp_q.push_back(exp_res);
        @(negedge clk);
        start    = 1'b1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (gap && i > 0) begin
                bit_valid = 1'b0;
                bit_in    = 1'b1;
                start     = 1'b0;
                @(negedge clk);
            end
            bit_valid = 1'b1;
            bit_in    = bits[i];
            start     = (i == start_at);
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        start     = 1'b0;
        chk({name, "_done_latency"}, int'(done), 1);
        chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
    endtask

    initial begin
        tests = 0; fails = 0; busy_cnt = 0;
        start = 0; clear = 0; bit_in = 0; bit_valid = 0;
        start1 = 0; clear1 = 0; bit_in1 = 0; bit_valid1 = 0;
        rst_b = 1'b0;
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_result_w1", int'(result1), 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        // Test 1: all ones.
        conv("all_ones", 15'h7FFF, 1'b0, -1, 15, 15);
        // Test 3: valid on every other cycle.
        conv("gapped_ones", 15'h7FFF, 1'b1, -1, 15, 29);
        // Test 2: all zeros, then alternating starting with 1.
        conv("all_zeros", 15'h0000, 1'b0, -1, 0, 15);
        conv("alternating", 15'h5555, 1'b0, -1, 8, 15);

        // Test 4: clear after 7 samples, coincident with an 8th valid sample.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        bit_valid = 1'b0;
        chk("clear_busy", int'(busy), 0);
        chk("clear_done", int'(done), 0);
        chk("clear_result_held", int'(result), 8);
        repeat (3) @(negedge clk);
        chk("clear_no_done", int'(done), 0);
        conv("after_clear", 15'h7FFF, 1'b0, -1, 15, 15);

        // Test 5: asynchronous reset after 5 samples.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_result", int'(result), 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);
        // Start pulse mid-conversion is ignored; ten ones in the window.
        conv("start_ignored", 15'h03FF, 1'b0, 5, 10, 15);

        // Test 6: WINDOW=1 instance, single sample then back-to-back with start held.
        @(negedge clk);
        exp1_q.push_back(1);
        exp1_q.push_back(0);
        start1     = 1'b1;
        bit_valid1 = 1'b1;
        bit_in1    = 1'b1;
        @(negedge clk);
        chk("w1_busy_count", int'(busy1), 1);
        @(negedge clk);
        chk("w1_done_latency", int'(done1), 1);
        bit_in1 = 1'b0;
        @(negedge clk);
        chk("w1_idle_between", int'(busy1), 0);
        @(negedge clk);
        chk("w1_restart_busy", int'(busy1), 1);
        @(negedge clk);
        chk("w1_second_done", int'(done1), 1);
        start1     = 1'b0;
        bit_valid1 = 1'b0;

        repeat (4) @(negedge clk);
        chk("w15_queue_drained", exp_q.size(), 0);
        chk("w1_queue_drained", exp1_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
